multicycle_main_fsm: RTL
========================

Name: multicycle_main_fsm

Overview:
Control FSM for the multi-cycle RV32I core. It replaces the single-cycle combinational main decoder. The block sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects and enables. It adds a ready/request handshake to the shared instruction/data memory, illegal-opcode detection and a retired-instruction counter. It sits beside the ALU decoder, which consumes alu_op.

Parameters:
OP_W, 7, opcode field width.
IMM_SRC_W, 3, immediate-select width; encodes I/S/B/J/U.
CNT_W, 32, width of the instret counter.
EN_JAL, 1, when 0, opcode 1101111 is treated as illegal.

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-low
op  in  OP_W  opcode of the instruction register (instr[6:0])
zero  in  1  ALU zero flag (used in BEQ state)
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested
pc_write  out  1  PC enable (pc_update | (branch & zero))
adr_src  out  1  0 = PC, 1 = ALU result register
mem_write  out  1  data store enable
ir_write  out  1  instruction register enable
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
alu_op  out  2  00 add, 01 sub/branch, 10 funct-decoded
imm_src  out  IMM_SRC_W  000 I, 001 S, 010 B, 011 J, 100 U
reg_write  out  1  register file write enable
illegal_op  out  1  one-cycle pulse on unsupported opcode
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH, instret=0, illegal_op=0. All other outputs follow from state FETCH.
- Only the state register, instret and illegal_op are registered. All other outputs are combinational from state and op (Moore style, plus op for imm_src).
- Any output not listed for a state is 0.
- imm_src is decoded from op in every state:
  - 0000011 / 0010011 -> 000
  - 0100011 -> 001
  - 1100011 -> 010
  - 1101111 -> 011
  - 0110111 -> 100
  - otherwise 000
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10. ir_write and pc_update are asserted only in the cycle mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01. Next state by op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 with EN_JAL=1 -> JAL
  - 0110111 -> LUI
  - otherwise -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01. Next state MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Waits on mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE: mem_req=1, adr_src=1. mem_write is asserted only in the cycle mem_ready=1. Waits on mem_ready, then goes to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next state ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next state ALUWB.
- LUI: alu_src_b=01, alu_op=00. The datapath zero-selects A on imm_src=100. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. pc_write = zero. Next state FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1. Next state ALUWB.
- ILLEGAL: illegal_op=1 for exactly this cycle; no register or memory writes. Next state FETCH. The PC was already advanced in FETCH, so the faulting instruction is skipped.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It does not increment from ILLEGAL. It wraps modulo 2^CNT_W.
- Instruction latencies with mem_ready always 1:
  - lw = 5 cycles; sw = 4
  - R-type / I-type / LUI = 4
  - beq = 3; jal = 4
- Each cycle with mem_ready=0 adds 1 cycle in FETCH, MEMREAD or MEMWRITE.
- mem_ready is ignored in states that do not assert mem_req.
- Reset asserted mid-instruction: FSM returns to FETCH immediately. A pending store is dropped, because mem_write is combinational from state.

Decomposition:
- Shared package riscv_pkg:
  - opcode localparams: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_LUI
  - state encoding localparams (4-bit)
  - IMM_* and RES_* select encodings
- One sub-module: imm_src_decoder (combinational op -> imm_src), shared with later pipeline work.
- The state register, next-state logic and output decode live in multicycle_main_fsm.

Test Plan:
- lw (op=0000011), mem_ready=1 throughout -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 in cycle 5 with result_src=01. instret goes 0 -> 1.
- sw with mem_ready held low for 3 cycles in MEMWRITE -> mem_req=1 and mem_write=0 for those 3 cycles, then mem_write=1 for exactly 1 cycle. 7 cycles total.
- beq with zero=1, then beq with zero=0 -> pc_write=1 in BEQ state only for the first. Both take 3 cycles. instret=2.
- op=1111111, then EN_JAL=0 with op=1101111 -> illegal_op pulses for 1 cycle in each case. No reg_write or mem_write. instret unchanged. FSM back in FETCH.
- Reset pulse (rst=0) asynchronously in EXECR, then a jal (op=1101111) -> outputs are FETCH values immediately on reset. instret=0. jal completes in 4 cycles: pc_write in JAL, reg_write in ALUWB.
- Preload instret=2^CNT_W-1 (or use CNT_W=4 and run 16 addi) -> counter wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: opcodes, FSM states and datapath selects.
// Imported by the multi-cycle control FSM and the immediate decoder.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_LUI      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath/memory (slave).
interface multicycle_main_fsm_if #(
    parameter int OP_W      = 7,
    parameter int IMM_SRC_W = 3,
    parameter int CNT_W     = 32
);
    logic [OP_W-1:0]      op;
    logic                 zero;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_write;
    logic                 ir_write;
    logic [1:0]           result_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_op;
    logic [IMM_SRC_W-1:0] imm_src;
    logic                 reg_write;
    logic                 illegal_op;
    logic [CNT_W-1:0]     instret;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, pc_write, adr_src, mem_write, ir_write,
        output result_src, alu_src_a, alu_src_b, alu_op,
        output imm_src, reg_write, illegal_op, instret
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, pc_write, adr_src, mem_write, ir_write,
        input  result_src, alu_src_a, alu_src_b, alu_op,
        input  imm_src, reg_write, illegal_op, instret
    );
endinterface

// File: rtl/multicycle_main_fsm_imm.sv
// Opcode to immediate-format select; reused by the later pipelined decode.
module imm_src_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [2:0] o_imm_src
);
    always_comb begin
        o_imm_src = IMM_I;
        case (i_op)
            OP_STORE:  o_imm_src = IMM_S;
            OP_BRANCH: o_imm_src = IMM_B;
            OP_JAL:    o_imm_src = IMM_J;
            OP_LUI:    o_imm_src = IMM_U;
            default:   o_imm_src = IMM_I;
        endcase
    end
endmodule

// File: rtl/multicycle_main_fsm.sv
// Multi-cycle RV32I main control FSM with memory handshake,
// illegal-opcode pulse and retired-instruction counter.
module multicycle_main_fsm
    import riscv_pkg::*;
#(
    parameter int OP_W      = 7,
    parameter int IMM_SRC_W = 3,
    parameter int CNT_W     = 32,
    parameter int EN_JAL    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_main_fsm_if.master   bus
);
    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             r_illegal;
    logic [OP_W-1:0]  w_op;
    logic [2:0]       w_imm_src;
    logic             w_retire;
    logic             w_pc_update;
    logic             w_branch;
    logic             w_mem_req;
    logic             w_adr_src;
    logic             w_mem_write;
    logic             w_ir_write;
    logic             w_reg_write;
    logic [1:0]       w_result_src;
    logic [1:0]       w_src_a;
    logic [1:0]       w_src_b;
    logic [1:0]       w_alu_op;

    assign w_op = bus.op;

    imm_src_decoder u_imm (
        .i_op      (w_op),
        .o_imm_src (w_imm_src)
    );

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BEQ;
                    OP_JAL:  w_next = (EN_JAL != 0) ? S_JAL : S_ILLEGAL;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  w_next = (w_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_LUI, S_JAL: w_next = S_ALUWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;
        w_alu_op     = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURES;
                w_ir_write   = bus.mem_ready;
                w_pc_update  = bus.mem_ready;
            end
            S_DECODE: begin
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_adr_src   = 1'b1;
                w_mem_write = bus.mem_ready;
            end
            S_EXECR: begin
                w_src_a  = SRCA_RS1;
                w_alu_op = ALU_FUNCT;
            end
            S_EXECI: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALU_FUNCT;
            end
            S_LUI:   w_src_b = SRCB_IMM;
            S_ALUWB: w_reg_write = 1'b1;
            S_BEQ: begin
                w_src_a  = SRCA_RS1;
                w_alu_op = ALU_SUB;
                w_branch = 1'b1;
            end
            S_JAL: begin
                w_src_a     = SRCA_OLDPC;
                w_src_b     = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // ILLEGAL is deliberately absent: a skipped instruction is not retired
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB)
                   || (r_state == S_BEQ)
                   || ((r_state == S_MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (w_next == S_ILLEGAL);
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.pc_write   = w_pc_update | (w_branch & bus.zero);
    assign bus.adr_src    = w_adr_src;
    assign bus.mem_write  = w_mem_write;
    assign bus.ir_write   = w_ir_write;
    assign bus.result_src = w_result_src;
    assign bus.alu_src_a  = w_src_a;
    assign bus.alu_src_b  = w_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.imm_src    = IMM_SRC_W'(w_imm_src);
    assign bus.reg_write  = w_reg_write;
    assign bus.illegal_op = r_illegal;
    assign bus.instret    = r_instret;
endmodule
